// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin scheduler sharing one ripple-carry adder among NREQ requesters.
//
// Each requester offers an operand pair with a valid/ready handshake. One winner per idle cycle
// is granted, its operands are latched and summed in the next cycle, and the (WIDTH+1)-bit sum
// is returned with the requester id on a valid/ready response port.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_valid_i  [NREQ]         per-requester request valid
//   req_ready_o  [NREQ]         one-hot grant, only in IDLE
//   req_a_i      [NREQ*WIDTH]   operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b_i      [NREQ*WIDTH]   operand B, same packing
//   rsp_valid_o                 response valid
//   rsp_ready_i                 response consumer ready
//   rsp_sum_o    [WIDTH+1]      A+B, MSB is carry-out
//   rsp_id_o     [IDW]          owner of the response
//   busy_o                      high whenever not IDLE
//   op_count_o   [16]           completed-operation counter
//
// Optional feature: define ADDER_SHARE_ARB_STATS_EN to implement op_count_o as a wrapping
// counter of response handshakes; otherwise op_count_o is tied to zero.

module adder_share_arb #(
    parameter int unsigned   WIDTH = 8,
    parameter int unsigned   NREQ  = 4,
    localparam int unsigned  IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid_i,
    output logic [NREQ-1:0]         req_ready_o,
    input  logic [NREQ*WIDTH-1:0]   req_a_i,
    input  logic [NREQ*WIDTH-1:0]   req_b_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [WIDTH:0]          rsp_sum_o,
    output logic [IDW-1:0]          rsp_id_o,
    output logic                    busy_o,
    output logic [15:0]             op_count_o
);

    typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH:0]   rsp_sum_q, rsp_sum_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic             rsp_valid_q, rsp_valid_d;

    // Round-robin search starting just after the last winner.
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   scan_idx;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            scan_idx = IDW'((32'(ptr_q) + k) % NREQ);
            if (!grant_found && req_valid_i[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Shared ripple-carry adder, carry-in tied low.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_bits;
    logic [WIDTH:0]   adder_sum;

    assign carry[0] = 1'b0;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum_bits[i]  = op_a_q[i] ^ op_b_q[i] ^ carry[i];
        assign carry[i + 1] = (op_a_q[i] & op_b_q[i]) | (carry[i] & (op_a_q[i] ^ op_b_q[i]));
    end
    assign adder_sum = {carry[WIDTH], sum_bits};

    logic rsp_hs;
    assign rsp_hs = rsp_valid_q & rsp_ready_i;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        req_ready_o = '0;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    req_ready_o[grant_idx] = 1'b1;
                    op_a_d  = req_a_i[32'(grant_idx) * WIDTH +: WIDTH];
                    op_b_d  = req_b_i[32'(grant_idx) * WIDTH +: WIDTH];
                    id_d    = grant_idx;
                    ptr_d   = grant_idx;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                rsp_sum_d   = adder_sum;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= IDW'(NREQ - 1);
            id_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_sum_o   = rsp_sum_q;
    assign rsp_id_o    = rsp_id_q;
    assign busy_o      = (state_q != StIdle);

`ifdef ADDER_SHARE_ARB_STATS_EN
    logic [15:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (rsp_hs) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count_o = op_count_q;
`else
    assign op_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_adder_share_arb.sv
// Scoreboard bench for adder_share_arb (WIDTH=8, NREQ=4): stimulus pushes expected {id,sum}
// at each grant; a negedge monitor pops and compares on every response handshake.

module tb_adder_share_arb;

    localparam int unsigned W   = 8;
    localparam int unsigned N   = 4;
    localparam int unsigned IW  = 2;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W:0]       rsp_sum;
    logic [IW-1:0]    rsp_id;
    logic             busy;
    logic [15:0]      op_count;

    adder_share_arb #(
        .WIDTH (W),
        .NREQ  (N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_sum_o   (rsp_sum),
        .rsp_id_o    (rsp_id),
        .busy_o      (busy),
        .op_count_o  (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;
    int exp_ops = 0;
    logic [IW+W:0] exp_q[$];
    logic [IW+W:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_count();
`ifdef ADDER_SHARE_ARB_STATS_EN
        chk("op_count", 32'(op_count), 32'(exp_ops & 32'hFFFF));
`else
        chk("op_count", 32'(op_count), 32'h0);
`endif
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered at posedge+1 with inputs set; returns at posedge+1 after the response handshake.
    task automatic run_op(input int g, input logic [W:0] s, input bit clobber);
        @(negedge clk);
        chk("grant", 32'(req_ready), 32'(1) << g);
        chk("busy_idle", 32'(busy), 32'h0);
        exp_q.push_back({IW'(g), s});
        step();
        if (clobber) set_op(g, 8'h00, 8'h00);
        @(negedge clk);
        chk("calc_ready", 32'(req_ready), 32'h0);
        chk("calc_busy", 32'(busy), 32'h1);
        chk("calc_valid", 32'(rsp_valid), 32'h0);
        step();
        @(negedge clk);
        chk("resp_valid", 32'(rsp_valid), 32'h1);
        chk("resp_ready", 32'(req_ready), 32'h0);
        step();
        exp_ops++;
        chk("busy_after", 32'(busy), 32'h0);
        chk_count();
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rsp: got id %0d sum %0h, expected no response",
                         rsp_id, rsp_sum);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_sum", 32'(rsp_sum), 32'(mon_e[W:0]));
                chk("rsp_id", 32'(rsp_id), 32'(mon_e[IW+W:W+1]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_sum", 32'(rsp_sum), 32'h0);
        chk("rst_id", 32'(rsp_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk_count();
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single request from requester 0
        req_valid = 4'b0001;
        set_op(0, 8'h0F, 8'h01);
        run_op(0, 9'h010, 1'b0);
        req_valid = '0;

        // Carry-out, operands clobbered after grant must not matter
        req_valid = 4'b0100;
        set_op(2, 8'hFF, 8'hFF);
        run_op(2, 9'h1FE, 1'b1);
        set_op(2, 8'h80, 8'h80);
        run_op(2, 9'h100, 1'b1);
        req_valid = 4'b1000;
        set_op(3, 8'h01, 8'h02);
        run_op(3, 9'h003, 1'b0);

        // Fairness: ptr=3, all valid -> 0,1,2,3,0
        set_op(0, 8'h10, 8'h01);
        set_op(1, 8'h20, 8'h02);
        set_op(2, 8'h30, 8'h03);
        set_op(3, 8'hF0, 8'h20);
        req_valid = 4'b1111;
        run_op(0, 9'h011, 1'b0);
        run_op(1, 9'h022, 1'b0);
        run_op(2, 9'h033, 1'b0);
        run_op(3, 9'h110, 1'b0);
        run_op(0, 9'h011, 1'b0);

        // Backpressure on requester 1's response
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_grant", 32'(req_ready), 32'h2);
        exp_q.push_back({IW'(1), 9'h022});
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_sum", 32'(rsp_sum), 32'h022);
            chk("bp_id", 32'(rsp_id), 32'h1);
            chk("bp_ready", 32'(req_ready), 32'h0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        exp_ops++;
        run_op(2, 9'h033, 1'b0);
        req_valid = '0;

        // Reset during CALC aborts the operation
        req_valid = 4'b0010;
        @(negedge clk);
        chk("abort_grant", 32'(req_ready), 32'h2);
        step();
        #2;
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        exp_ops = 0;
        chk("abort_valid", 32'(rsp_valid), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_sum", 32'(rsp_sum), 32'h0);
        chk("abort_id", 32'(rsp_id), 32'h0);
        chk("abort_ready", 32'(req_ready), 32'h0);
        chk_count();
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_norsp", 32'(rsp_valid), 32'h0);
            step();
        end

        // After reset requester 0 has priority; three ops for the counter
        req_valid = 4'b1111;
        run_op(0, 9'h011, 1'b0);
        run_op(1, 9'h022, 1'b0);
        run_op(2, 9'h033, 1'b0);
        req_valid = '0;

        step();
        step();
        chk("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
